// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : Memory-stage controller; drives a multi-cycle data memory through
//            a stall/done handshake and updates the MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_DMemEn,
    input  logic        ex_DMemWrite,
    input  logic        ex_DMemDump,
    input  logic        ex_MemToReg,
    input  logic        ex_RegWrite,
    input  logic [2:0]  ex_WriteRegister,
    input  logic [15:0] ex_aluOutput,
    input  logic [15:0] ex_B,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_dump,
    input  logic        mem_stall,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        pipe_stall,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [2:0]  wb_WriteRegister,
    output logic [15:0] wb_data,
    output logic        err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    localparam int              c_CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_WAIT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_nextState;
    logic [c_CNT_W-1:0] r_count;
    logic               w_cntClr;
    logic               w_cntInc;
    logic               w_memEn;
    logic               w_dump;
    logic               w_stall;
    logic               w_acc;
    logic               w_mis;
    logic               w_retire;

    assign w_acc = ex_valid & ex_DMemEn;
    assign w_mis = w_acc & ex_aluOutput[0];

    always_comb begin
        w_nextState = r_state;
        w_cntClr    = 1'b0;
        w_cntInc    = 1'b0;
        w_memEn     = 1'b0;
        w_dump      = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (ex_valid & ex_DMemDump) begin
                    w_dump      = 1'b1;
                    w_stall     = 1'b1;
                    w_nextState = c_HALT;
                end else if (w_mis) begin
                    w_stall     = 1'b1;
                    w_nextState = c_ERR;
                end else if (w_acc) begin
                    w_memEn = 1'b1;
                    if (mem_done) begin
                        w_stall = 1'b0;
                    end else if (mem_stall) begin
                        w_stall = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_cntClr    = 1'b1;
                        w_nextState = c_WAIT;
                    end
                end
            end
            c_WAIT: begin
                if (mem_done) begin
                    w_nextState = c_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_count == c_CNT_LAST) begin
                        w_nextState = c_ERR;
                    end else begin
                        w_cntInc = 1'b1;
                    end
                end
            end
            default: begin
                w_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_cntClr) begin
                r_count <= '0;
            end else if (w_cntInc) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Handshake outputs drop the moment reset asserts, not at the next edge.
    assign mem_en     = w_memEn & ~rst;
    assign mem_wr     = w_memEn & ex_DMemWrite & ~rst;
    assign mem_dump   = w_dump & ~rst;
    assign pipe_stall = w_stall & ~rst;
    assign mem_addr   = ex_aluOutput;
    assign mem_wdata  = ex_B;
    assign err        = (r_state == c_ERR);

    assign w_retire = ex_valid & ~w_stall & ((r_state == c_IDLE) | (r_state == c_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid         <= 1'b0;
            wb_RegWrite      <= 1'b0;
            wb_WriteRegister <= 3'd0;
            wb_data          <= 16'd0;
        end else if (w_retire) begin
            wb_valid         <= 1'b1;
            wb_RegWrite      <= ex_RegWrite;
            wb_WriteRegister <= ex_WriteRegister;
            wb_data          <= (ex_MemToReg & ~ex_DMemWrite) ? mem_rdata : ex_aluOutput;
        end else begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Brief    : Directed self-checking bench for mem_stage_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

    localparam int c_MAX_WAIT = 15;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_DMemEn;
    logic        ex_DMemWrite;
    logic        ex_DMemDump;
    logic        ex_MemToReg;
    logic        ex_RegWrite;
    logic [2:0]  ex_WriteRegister;
    logic [15:0] ex_aluOutput;
    logic [15:0] ex_B;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_dump;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        pipe_stall;
    logic        wb_valid;
    logic        wb_RegWrite;
    logic [2:0]  wb_WriteRegister;
    logic [15:0] wb_data;
    logic        err;

    int checks = 0;
    int errors = 0;
    int enCount;
    int retCount;
    int stallCount;
    int dumpCount;

    mem_stage_ctrl #(.MAX_WAIT(c_MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_DMemEn(ex_DMemEn), .ex_DMemWrite(ex_DMemWrite),
        .ex_DMemDump(ex_DMemDump), .ex_MemToReg(ex_MemToReg), .ex_RegWrite(ex_RegWrite),
        .ex_WriteRegister(ex_WriteRegister), .ex_aluOutput(ex_aluOutput), .ex_B(ex_B),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_dump(mem_dump), .mem_stall(mem_stall), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall), .wb_valid(wb_valid),
        .wb_RegWrite(wb_RegWrite), .wb_WriteRegister(wb_WriteRegister),
        .wb_data(wb_data), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setEx(input logic v, input logic en, input logic wr, input logic dmp,
                         input logic m2r, input logic rw, input logic [2:0] wreg,
                         input logic [15:0] alu, input logic [15:0] b);
        ex_valid = v; ex_DMemEn = en; ex_DMemWrite = wr; ex_DMemDump = dmp;
        ex_MemToReg = m2r; ex_RegWrite = rw; ex_WriteRegister = wreg;
        ex_aluOutput = alu; ex_B = b;
    endtask

    task automatic bubble();
        setEx(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0000;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bubble();
        #3;
        doReset();

        // Reset state
        chk("reset_wb_valid", 16'(wb_valid), 16'd0);
        chk("reset_wb_data", wb_data, 16'h0000);
        chk("reset_err", 16'(err), 16'd0);
        chk("reset_pipe_stall", 16'(pipe_stall), 16'd0);
        chk("reset_mem_en", 16'(mem_en), 16'd0);

        // Plain ALU instruction retires with its ALU result
        setEx(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h7777, 16'h0000);
        #1;
        chk("alu_mem_en", 16'(mem_en), 16'd0);
        chk("alu_pipe_stall", 16'(pipe_stall), 16'd0);
        tick();
        chk("alu_wb_valid", 16'(wb_valid), 16'd1);
        chk("alu_wb_data", wb_data, 16'h7777);
        chk("alu_wb_reg", 16'(wb_WriteRegister), 16'd2);

        // 1: load hit, same-cycle completion
        setEx(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 16'h0010, 16'h0000);
        mem_done = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        chk("hit_mem_en", 16'(mem_en), 16'd1);
        chk("hit_mem_wr", 16'(mem_wr), 16'd0);
        chk("hit_mem_addr", mem_addr, 16'h0010);
        chk("hit_pipe_stall", 16'(pipe_stall), 16'd0);
        tick();
        chk("hit_wb_valid", 16'(wb_valid), 16'd1);
        chk("hit_wb_data", wb_data, 16'hBEEF);
        chk("hit_wb_regwrite", 16'(wb_RegWrite), 16'd1);
        chk("hit_wb_reg", 16'(wb_WriteRegister), 16'd3);
        bubble();
        #1;
        chk("bubble_pipe_stall", 16'(pipe_stall), 16'd0);
        tick();
        chk("bubble_wb_valid", 16'(wb_valid), 16'd0);
        chk("bubble_wb_regwrite", 16'(wb_RegWrite), 16'd0);
        chk("bubble_wb_data_hold", wb_data, 16'hBEEF);

        // 2: store, done arrives 3 cycles after the accepting cycle
        setEx(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 16'h0020, 16'h1234);
        #1;
        chk("st_mem_en", 16'(mem_en), 16'd1);
        chk("st_mem_wr", 16'(mem_wr), 16'd1);
        chk("st_mem_wdata", mem_wdata, 16'h1234);
        stallCount = 0; enCount = 0;
        for (int i = 0; i < 3; i++) begin
            if (pipe_stall) stallCount++;
            if (mem_en) enCount++;
            chk("st_wb_regwrite_wait", 16'(wb_RegWrite), 16'd0);
            tick();
        end
        chk("st_stall_cycles", 16'(stallCount), 16'd3);
        chk("st_en_cycles", 16'(enCount), 16'd1);
        mem_done = 1'b1;
        #1;
        chk("st_done_pipe_stall", 16'(pipe_stall), 16'd0);
        chk("st_done_mem_en", 16'(mem_en), 16'd0);
        tick();
        chk("st_wb_valid", 16'(wb_valid), 16'd1);
        chk("st_wb_regwrite", 16'(wb_RegWrite), 16'd0);
        chk("st_wb_data", wb_data, 16'h0020);
        bubble();
        tick();

        // 3: two refused cycles, accept, done one cycle later
        setEx(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'h0030, 16'h0000);
        enCount = 0; retCount = 0;
        for (int i = 0; i < 4; i++) begin
            mem_stall = (i < 2);
            mem_done  = (i == 3);
            mem_rdata = (i == 3) ? 16'hCAFE : 16'h0000;
            #1;
            if (mem_en) enCount++;
            tick();
            if (wb_valid) retCount++;
        end
        chk("rty_wb_data", wb_data, 16'hCAFE);
        chk("rty_wb_reg", 16'(wb_WriteRegister), 16'd5);
        bubble();
        tick();
        if (wb_valid) retCount++;
        chk("rty_en_cycles", 16'(enCount), 16'd3);
        chk("rty_retires", 16'(retCount), 16'd1);

        // 5: timeout with no mem_done
        setEx(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h0040, 16'h0000);
        tick();
        stallCount = 0;
        for (int i = 0; i < c_MAX_WAIT; i++) begin
            chk("to_err_early", 16'(err), 16'd0);
            if (pipe_stall) stallCount++;
            tick();
        end
        chk("to_wait_stall", 16'(stallCount), 16'(c_MAX_WAIT));
        chk("to_err", 16'(err), 16'd1);
        chk("to_pipe_stall", 16'(pipe_stall), 16'd1);
        mem_done = 1'b1;
        tick();
        chk("to_stuck_stall", 16'(pipe_stall), 16'd1);
        chk("to_stuck_wb_valid", 16'(wb_valid), 16'd0);
        chk("to_stuck_mem_en", 16'(mem_en), 16'd0);
        bubble();
        doReset();
        chk("to_reset_err", 16'(err), 16'd0);

        // Async reset mid-WAIT drops handshake outputs without a clock edge
        setEx(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h0050, 16'h0000);
        tick();
        chk("arst_pre_stall", 16'(pipe_stall), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pipe_stall", 16'(pipe_stall), 16'd0);
        chk("arst_mem_en", 16'(mem_en), 16'd0);
        bubble();
        #1;
        rst = 1'b0;
        tick();

        // 4: misaligned access goes to ERR
        setEx(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 16'h0011, 16'h0000);
        #1;
        chk("mis_mem_en", 16'(mem_en), 16'd0);
        chk("mis_pipe_stall", 16'(pipe_stall), 16'd1);
        tick();
        chk("mis_err", 16'(err), 16'd1);
        chk("mis_mem_en_err", 16'(mem_en), 16'd0);
        chk("mis_wb_valid", 16'(wb_valid), 16'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mis_rst_err", 16'(err), 16'd0);
        chk("mis_rst_pipe_stall", 16'(pipe_stall), 16'd0);
        chk("mis_rst_wb_data", wb_data, 16'h0000);
        bubble();
        #1;
        rst = 1'b0;
        tick();

        // 6: dump (with DMemEn also set) halts the pipeline
        setEx(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0060, 16'h0000);
        #1;
        chk("dump_strobe", 16'(mem_dump), 16'd1);
        chk("dump_priority_mem_en", 16'(mem_en), 16'd0);
        chk("dump_pipe_stall", 16'(pipe_stall), 16'd1);
        tick();
        dumpCount = 0; stallCount = 0;
        for (int i = 0; i < 22; i++) begin
            if (mem_dump) dumpCount++;
            if (pipe_stall) stallCount++;
            tick();
        end
        chk("dump_once", 16'(dumpCount), 16'd0);
        chk("dump_halt_stall", 16'(stallCount), 16'd22);
        chk("dump_wb_valid", 16'(wb_valid), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
